// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Fetch stage of the SCC core. It owns the program counter, reads the
//   instruction ROM asynchronously and presents the captured word to decode
//   through a valid/ready output register. It also handles stalls, branch
//   redirects, the halt word and 16-bit PC wrap-around.
//
// Ports
//   Clk, Rst                core clock, asynchronous active-high reset
//   instruction_memory_en   ROM read enable (high only while fetching)
//   instruction_memory_a    ROM byte address, always equal to the PC
//   instruction_memory_v    ROM data, combinational from the address
//   branch_taken/_target    redirect request from execute
//   if_ready                decode accepts the presented word this cycle
//   if_valid/if_instr/if_pc presented instruction, its byte address
//   halted                  fetch stopped on HALT_WORD
//   fetch_count             saturating count of words accepted by decode
module instruction_fetch #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter logic [15:0] PC_STEP   = 16'd4
) (
    input  logic        Clk,
    input  logic        Rst,
    output logic        instruction_memory_en,
    output logic [15:0] instruction_memory_a,
    input  logic [31:0] instruction_memory_v,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        if_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [15:0] if_pc,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [15:0] if_pc_q, if_pc_d;
    logic        halted_q, halted_d;
    logic        en_q, en_d;
    logic [15:0] fetch_count_q, fetch_count_d;

    logic adv;
    logic accept;

    // The output register can take a new word when it is empty or being drained.
    assign adv    = !if_valid_q || if_ready;
    assign accept = if_valid_q && if_ready;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        fetch_count_d = fetch_count_q;

        // A word flushed by a redirect in the same cycle is not counted.
        if (accept && !branch_taken && fetch_count_q != 16'hFFFF) begin
            fetch_count_d = fetch_count_q + 16'd1;
        end

        case (state_q)
            ST_BOOT: begin
                // Redirects are ignored while the stage is still coming out of reset.
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (branch_taken) begin
                    pc_d       = {branch_target[15:2], 2'b00};
                    if_valid_d = 1'b0;
                end else if (adv) begin
                    if_instr_d = instruction_memory_v;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    if (instruction_memory_v == HALT_WORD) begin
                        // PC stays on the halt word; only a redirect moves it.
                        state_d = ST_HALT;
                    end else begin
                        pc_d = pc_q + PC_STEP;
                    end
                end
            end
            ST_HALT: begin
                if (branch_taken) begin
                    pc_d       = {branch_target[15:2], 2'b00};
                    if_valid_d = 1'b0;
                    state_d    = ST_FETCH;
                end else if (accept) begin
                    if_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        // Enable and halted are registered decodes of the next state.
        en_d     = (state_d == ST_FETCH);
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_instr_q    <= 32'h0;
            if_pc_q       <= 16'h0;
            halted_q      <= 1'b0;
            en_q          <= 1'b0;
            fetch_count_q <= 16'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            halted_q      <= halted_d;
            en_q          <= en_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign instruction_memory_en = en_q;
    assign instruction_memory_a  = pc_q;
    assign if_valid              = if_valid_q;
    assign if_instr              = if_instr_q;
    assign if_pc                 = if_pc_q;
    assign halted                = halted_q;
    assign fetch_count           = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a ROM array, a behavioural model of
// the fetch stage checked every negative edge, plus literal expectations.
module tb_instruction_fetch;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        en;
    logic [15:0] addr;
    logic [31:0] rdata;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0;
    logic        if_ready = 1'b1;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [15:0] if_pc;
    logic        halted;
    logic [15:0] fetch_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] rom [0:16383];

    always #5 Clk = ~Clk;

    assign rdata = rom[addr[15:2]];

    instruction_fetch dut (
        .Clk                  (Clk),
        .Rst                  (Rst),
        .instruction_memory_en(en),
        .instruction_memory_a (addr),
        .instruction_memory_v (rdata),
        .branch_taken         (branch_taken),
        .branch_target        (branch_target),
        .if_ready             (if_ready),
        .if_valid             (if_valid),
        .if_instr             (if_instr),
        .if_pc                (if_pc),
        .halted               (halted),
        .fetch_count          (fetch_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the stage must present, from the stated rules.
    logic        m_boot   = 1'b1;
    logic        m_halted = 1'b0;
    logic        m_valid  = 1'b0;
    logic [31:0] m_instr  = 32'h0;
    logic [15:0] m_ipc    = 16'h0;
    logic [15:0] m_pc     = 16'h0;
    int          m_count  = 0;

    always @(posedge Clk or posedge Rst) begin
        logic        acc;
        logic [31:0] w;
        if (Rst) begin
            m_boot <= 1'b1; m_halted <= 1'b0; m_valid <= 1'b0;
            m_instr <= 32'h0; m_ipc <= 16'h0; m_pc <= 16'h0; m_count <= 0;
        end else begin
            acc = m_valid && if_ready;
            if (acc && !branch_taken && m_count < 65535) m_count <= m_count + 1;
            if (m_boot) begin
                m_boot <= 1'b0;
            end else if (branch_taken) begin
                m_pc     <= branch_target & 16'hFFFC;
                m_valid  <= 1'b0;
                m_halted <= 1'b0;
            end else if (m_halted) begin
                if (acc) m_valid <= 1'b0;
            end else if (!m_valid || if_ready) begin
                w = rom[m_pc / 4];
                m_instr <= w;
                m_ipc   <= m_pc;
                m_valid <= 1'b1;
                if (w == HALT) m_halted <= 1'b1;
                else m_pc <= 16'((32'(m_pc) + 4) % 65536);
            end
        end
    end

    always @(negedge Clk) begin
        if (!Rst) begin
            check("m_en", {31'h0, en}, {31'h0, !m_boot && !m_halted});
            check("m_addr", {16'h0, addr}, {16'h0, m_pc});
            check("m_valid", {31'h0, if_valid}, {31'h0, m_valid});
            if (m_valid) begin
                check("m_instr", if_instr, m_instr);
                check("m_if_pc", {16'h0, if_pc}, {16'h0, m_ipc});
            end
            check("m_halted", {31'h0, halted}, {31'h0, m_halted});
            check("m_count", {16'h0, fetch_count}, m_count);
        end
    end

    task automatic step();
        @(negedge Clk);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) rom[i] = {i[15:0], ~i[15:0]};
        rom[0] = 32'h11223344;
        rom[1] = 32'h55667788;
        rom[2] = 32'h99AABBCC;
        rom[3] = 32'hDDEEFF00;
        rom[4] = HALT;

        #1 Rst = 1'b1;
        #2;
        check("rst_valid", {31'h0, if_valid}, 32'h0);
        check("rst_en", {31'h0, en}, 32'h0);
        check("rst_addr", {16'h0, addr}, 32'h0);
        check("rst_instr", if_instr, 32'h0);
        check("rst_pc", {16'h0, if_pc}, 32'h0);
        check("rst_count", {16'h0, fetch_count}, 32'h0);
        check("rst_halted", {31'h0, halted}, 32'h0);

        // Sequential fetch; a branch during BOOT must be ignored.
        step(); Rst = 1'b0; branch_taken = 1'b1; branch_target = 16'h0040;
        step(); branch_taken = 1'b0;
        check("boot_en", {31'h0, en}, 32'h1);
        check("boot_valid", {31'h0, if_valid}, 32'h0);
        check("boot_addr", {16'h0, addr}, 32'h0);
        step();
        check("seq0_instr", if_instr, 32'h11223344);
        check("seq0_pc", {16'h0, if_pc}, 32'h0);
        step();
        check("seq1_instr", if_instr, 32'h55667788);
        check("seq1_pc", {16'h0, if_pc}, 32'h4);

        // Stall three cycles holding word 1.
        if_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_instr", if_instr, 32'h55667788);
            check("stall_pc", {16'h0, if_pc}, 32'h4);
            check("stall_addr", {16'h0, addr}, 32'h8);
            check("stall_count", {16'h0, fetch_count}, 32'h1);
        end
        if_ready = 1'b1;
        step();
        check("seq2_instr", if_instr, 32'h99AABBCC);
        check("seq2_pc", {16'h0, if_pc}, 32'h8);
        step();
        check("seq3_instr", if_instr, 32'hDDEEFF00);
        check("seq3_pc", {16'h0, if_pc}, 32'hC);

        // Halt word at 0x10.
        step();
        check("halt_instr", if_instr, HALT);
        check("halt_valid", {31'h0, if_valid}, 32'h1);
        check("halt_flag", {31'h0, halted}, 32'h1);
        check("halt_en", {31'h0, en}, 32'h0);
        check("halt_addr", {16'h0, addr}, 32'h10);
        check("halt_count4", {16'h0, fetch_count}, 32'h4);
        repeat (4) step();
        check("halt_hold_valid", {31'h0, if_valid}, 32'h0);
        check("halt_hold_flag", {31'h0, halted}, 32'h1);
        check("halt_hold_addr", {16'h0, addr}, 32'h10);
        check("halt_hold_count", {16'h0, fetch_count}, 32'h5);

        // Restart from 0 via redirect.
        branch_taken = 1'b1; branch_target = 16'h0000;
        step(); branch_taken = 1'b0;
        check("restart_halted", {31'h0, halted}, 32'h0);
        check("restart_valid", {31'h0, if_valid}, 32'h0);
        step();
        check("restart_instr", if_instr, 32'h11223344);

        // Redirect while stalled, misaligned target.
        if_ready = 1'b0;
        step();
        branch_taken = 1'b1; branch_target = 16'h0023;
        step(); branch_taken = 1'b0; if_ready = 1'b1;
        check("redir_valid", {31'h0, if_valid}, 32'h0);
        check("redir_addr", {16'h0, addr}, 32'h20);
        check("redir_count", {16'h0, fetch_count}, 32'h5);
        step();
        check("redir_instr", if_instr, 32'h0008FFF7);
        check("redir_pc", {16'h0, if_pc}, 32'h20);

        // Redirect while decode accepts: the flushed word is not counted.
        branch_taken = 1'b1; branch_target = 16'hFFFC;
        step(); branch_taken = 1'b0;
        check("wrap_redir_count", {16'h0, fetch_count}, 32'h5);
        step();
        check("wrap_pc_hi", {16'h0, if_pc}, 32'hFFFC);
        check("wrap_instr_hi", if_instr, 32'h3FFFC000);
        step();
        check("wrap_pc_lo", {16'h0, if_pc}, 32'h0);
        check("wrap_instr_lo", if_instr, 32'h11223344);

        // Async reset in the middle of a stall.
        if_ready = 1'b0;
        step(); step();
        #2 Rst = 1'b1;
        #1;
        check("arst_valid", {31'h0, if_valid}, 32'h0);
        check("arst_addr", {16'h0, addr}, 32'h0);
        check("arst_count", {16'h0, fetch_count}, 32'h0);
        check("arst_en", {31'h0, en}, 32'h0);
        step(); Rst = 1'b0; if_ready = 1'b1;
        step();
        check("arst_boot_valid", {31'h0, if_valid}, 32'h0);
        step();
        check("arst_resume_instr", if_instr, 32'h11223344);
        check("arst_resume_valid", {31'h0, if_valid}, 32'h1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage of the SCC core. Sits directly upstream of the instruction ROM and downstream into decode.
- Holds the program counter (PC), drives the ROM byte address and enable, and captures the 32-bit word the ROM returns asynchronously.
- Presents that word to decode through a valid/ready output register.
- Handles stalls, branch redirects, a halt word and PC wrap-around.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HALT_WORD, 32'hFFFF_FFFF, instruction word that stops fetching.
- PC_STEP, 4, byte increment per fetched instruction.

Ports:
- Clk  input  1  core clock; all state updates on the rising edge.
- Rst  input  1  asynchronous, active-high reset.
- instruction_memory_en  output  1  ROM read enable.
- instruction_memory_a  output  16  ROM byte address; always equals PC.
- instruction_memory_v  input  32  ROM data; combinational from instruction_memory_a.
- branch_taken  input  1  redirect request from execute.
- branch_target  input  16  redirect byte address.
- if_ready  input  1  decode can accept this cycle.
- if_valid  output  1  if_instr/if_pc hold a valid instruction.
- if_instr  output  32  fetched instruction word.
- if_pc  output  16  byte address of if_instr.
- halted  output  1  fetch stopped on HALT_WORD.
- fetch_count  output  16  instructions accepted by decode; saturating.

Behaviour:
- Reset (async, Rst=1):
  - PC=RESET_PC; state=BOOT.
  - if_valid=0, if_instr=0, if_pc=0, halted=0, fetch_count=0, instruction_memory_en=0.
  - Reset mid-operation discards all in-flight state, with no partial update.
- States:
  - BOOT: en=0; one cycle after reset release, then go to FETCH.
  - FETCH: en=1.
  - HALT: en=0, halted=1.
- Advance condition in FETCH: adv = (!if_valid || if_ready).
- On adv with no redirect:
  - if_instr <= instruction_memory_v; if_pc <= PC; if_valid <= 1.
  - PC <= PC + PC_STEP, modulo 2^16, so 16'hFFFC wraps to 16'h0000.
- No adv (stall): PC, if_instr, if_pc and if_valid hold. Outputs are stable while if_valid=1 and if_ready=0.
- Fetch latency: the word at address A appears on if_instr with if_valid=1 on the edge after the cycle in which PC==A and adv=1.
- Halt:
  - If the captured word equals HALT_WORD, it is still presented with if_valid=1, and the state goes to HALT. PC is not incremented.
  - In HALT, if_valid clears once decode accepts the word (if_valid && if_ready).
  - HALT exits only via branch_taken or Rst.
- Redirect (branch_taken=1), in any state except BOOT:
  - PC <= {branch_target[15:2], 2'b00}; misaligned targets are silently aligned.
  - if_valid <= 0, flushing the held word; state <= FETCH; halted <= 0.
  - The first new instruction is valid two edges after the redirect cycle.
  - Redirect has priority over stall, halt detection and capture in the same cycle.
  - branch_taken during BOOT is ignored.
- fetch_count increments on every edge where if_valid && if_ready && !branch_taken. It saturates at 16'hFFFF.
- Address output: instruction_memory_a = PC combinationally; no extra register.

Test Plan:
- Sequential fetch: ROM bytes 0..15 hold words 11223344, 55667788, 99AABBCC, DDEEFF00; if_ready=1 after reset. Required: one edge in BOOT. Then if_instr gives the four words on consecutive cycles, with if_pc=0,4,8,C. fetch_count reaches 4.
- Stall: if_ready=0 for 3 cycles while holding 55667788 at if_pc=4. Required: if_instr, if_pc and PC (=8) unchanged for all 3 cycles. When if_ready returns to 1, the next word is 99AABBCC with no word skipped or duplicated.
- Redirect priority: branch_taken=1 with branch_target=16'h0023 while if_ready=0. Required: if_valid=0 next edge and PC=16'h0020. The word at 0x20 is valid two edges after the redirect cycle. fetch_count does not increment in the redirect cycle.
- Halt: word FFFFFFFF at 0x10. Required: the word is presented with if_valid=1, then halted=1, en=0, PC=0x10. The state holds indefinitely. branch_taken with target 0 clears halted and restarts fetch from 0.
- Wrap-around: branch to 16'hFFFC with if_ready=1. Required: if_pc=FFFC, then if_pc=0000 on the next accepted instruction.
- Async reset mid-stall: assert Rst between clock edges. Required: if_valid=0, PC=RESET_PC, fetch_count=0 immediately, before the next edge. Fetch resumes after one BOOT cycle.
